// File: rtl/mult_pkg.sv
// mult_pkg: shared FSM state type and iteration/counter sizing for the sequential multiplier.
package mult_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, SIGN, DONE} state_e;

    function automatic int n_iter(input int xlen, input int bpc);
        return xlen / bpc;
    endfunction

    // A single-iteration configuration still needs a 1-bit counter.
    function automatic int cnt_w(input int xlen, input int bpc);
        return (n_iter(xlen, bpc) > 1) ? $clog2(n_iter(xlen, bpc)) : 1;
    endfunction

    function automatic bit cfg_ok(input int xlen, input int bpc);
        return (xlen == 32 || xlen == 64) && bpc > 0 && (bpc & (bpc - 1)) == 0 && (xlen % bpc) == 0;
    endfunction

endpackage

// File: rtl/mult_step.sv
// mult_step: one radix-2^BPC iteration, acc + |A| * digit shifted to the digit's position.
module mult_step
    import mult_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int BPC  = 8,
    parameter int CW   = cnt_w(XLEN, BPC)
) (
    input  logic [XLEN-1:0]   a_i,
    input  logic [BPC-1:0]    digit_i,
    input  logic [CW-1:0]     cnt_i,
    input  logic [2*XLEN-1:0] acc_i,
    output logic [2*XLEN-1:0] acc_o
);
    localparam int SW = CW + $clog2(BPC);

    logic [XLEN+BPC-1:0] pp;
    logic [SW-1:0]       sh;

    always_comb begin
        pp    = (XLEN+BPC)'(a_i) * (XLEN+BPC)'(digit_i);
        sh    = SW'(cnt_i) << $clog2(BPC);
        acc_o = acc_i + ((2*XLEN)'(pp) << sh);
    end

endmodule

// File: rtl/mult_seq_param.sv
// mult_seq_param: sequential MUL/MULH/MULHSU/MULHU, BITS_PER_CYCLE multiplier bits per cycle,
// with a one-entry product cache so a repeated operand pair answers in one cycle.
module mult_seq_param
    import mult_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 8
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [XLEN-1:0] op_A_i,
    input  logic [XLEN-1:0] op_B_i,
    input  logic            signed_A_i,
    input  logic            signed_B_i,
    input  logic            upper_i,
    input  logic            kill_i,
    output logic            rsp_valid_o,
    input  logic            rsp_ready_i,
    output logic [XLEN-1:0] result_o
);
    localparam int            N_ITER = n_iter(XLEN, BITS_PER_CYCLE);
    localparam int            CW     = cnt_w(XLEN, BITS_PER_CYCLE);
    localparam logic [CW-1:0] LAST   = CW'(N_ITER - 1);

    if (!cfg_ok(XLEN, BITS_PER_CYCLE)) begin : g_bad_cfg
        $error("mult_seq_param: XLEN must be 32 or 64 and BITS_PER_CYCLE a power of two dividing it");
    end

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [XLEN-1:0]   a_mag_q, a_mag_d, b_mag_q, b_mag_d;
    logic              neg_q, neg_d, upper_q, upper_d;
    logic [2*XLEN-1:0] acc_q, acc_d, acc_step, prod_q, prod_d;
    logic [XLEN-1:0]   tag_a_q, tag_a_d, tag_b_q, tag_b_d;
    logic              tag_sa_q, tag_sa_d, tag_sb_q, tag_sb_d, cvalid_q, cvalid_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              accept, hit;

    assign accept      = state_q == IDLE && req_valid_i && !kill_i;
    assign hit         = cvalid_q && tag_a_q == op_A_i && tag_b_q == op_B_i &&
                         tag_sa_q == signed_A_i && tag_sb_q == signed_B_i;
    assign req_ready_o = state_q == IDLE;
    assign rsp_valid_o = state_q == DONE;
    assign result_o    = result_q;

    mult_step #(.XLEN(XLEN), .BPC(BITS_PER_CYCLE), .CW(CW)) u_step (
        .a_i     (a_mag_q),
        .digit_i (b_mag_q[BITS_PER_CYCLE-1:0]),
        .cnt_i   (cnt_q),
        .acc_i   (acc_q),
        .acc_o   (acc_step)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (kill_i) state_d = IDLE;
        else begin
            case (state_q)
                IDLE: if (req_valid_i) state_d = hit ? DONE : BUSY;
                BUSY: if (cnt_q == LAST) state_d = SIGN;
                SIGN: state_d = DONE;
                DONE: if (rsp_ready_i) state_d = IDLE;
            endcase
        end
    end

    // The tag is written at a miss accept with the cache marked invalid, so it
    // only becomes usable once SIGN has stored the matching product.
    always_comb begin
        cnt_d    = cnt_q;
        a_mag_d  = a_mag_q;
        b_mag_d  = b_mag_q;
        neg_d    = neg_q;
        upper_d  = upper_q;
        acc_d    = acc_q;
        prod_d   = prod_q;
        tag_a_d  = tag_a_q;
        tag_b_d  = tag_b_q;
        tag_sa_d = tag_sa_q;
        tag_sb_d = tag_sb_q;
        cvalid_d = cvalid_q && !(kill_i && state_q != IDLE);
        result_d = result_q;
        if (accept) begin
            a_mag_d = (signed_A_i && op_A_i[XLEN-1]) ? -op_A_i : op_A_i;
            b_mag_d = (signed_B_i && op_B_i[XLEN-1]) ? -op_B_i : op_B_i;
            neg_d   = (signed_A_i && op_A_i[XLEN-1]) ^ (signed_B_i && op_B_i[XLEN-1]);
            upper_d = upper_i;
            cnt_d   = '0;
            acc_d   = '0;
            if (hit) result_d = upper_i ? prod_q[2*XLEN-1:XLEN] : prod_q[XLEN-1:0];
            else begin
                tag_a_d  = op_A_i;
                tag_b_d  = op_B_i;
                tag_sa_d = signed_A_i;
                tag_sb_d = signed_B_i;
                cvalid_d = 1'b0;
            end
        end
        if (state_q == BUSY) begin
            acc_d   = acc_step;
            b_mag_d = b_mag_q >> BITS_PER_CYCLE;
            cnt_d   = cnt_q + 1'b1;
        end
        if (state_q == SIGN && !kill_i) begin
            prod_d   = neg_q ? -acc_q : acc_q;
            cvalid_d = 1'b1;
            result_d = upper_q ? prod_d[2*XLEN-1:XLEN] : prod_d[XLEN-1:0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q    <= '0;
            a_mag_q  <= '0;
            b_mag_q  <= '0;
            neg_q    <= 1'b0;
            upper_q  <= 1'b0;
            acc_q    <= '0;
            prod_q   <= '0;
            tag_a_q  <= '0;
            tag_b_q  <= '0;
            tag_sa_q <= 1'b0;
            tag_sb_q <= 1'b0;
            cvalid_q <= 1'b0;
            result_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            a_mag_q  <= a_mag_d;
            b_mag_q  <= b_mag_d;
            neg_q    <= neg_d;
            upper_q  <= upper_d;
            acc_q    <= acc_d;
            prod_q   <= prod_d;
            tag_a_q  <= tag_a_d;
            tag_b_q  <= tag_b_d;
            tag_sa_q <= tag_sa_d;
            tag_sb_q <= tag_sb_d;
            cvalid_q <= cvalid_d;
            result_q <= result_d;
        end
    end

endmodule

// File: tb/tb_mult_seq_param.sv
// tb_mult_seq_param: scoreboard bench for a 32/8 and a 64/16 instance against a wide-arithmetic product model.
module tb_mult_seq_param;

    localparam int LAT_MISS = 6;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rv32, rr32, sa32, sb32, up32, k32, sv32, sr32;
    logic [31:0] a32, b32, res32;
    logic        rv64, rr64, sa64, sb64, up64, k64, sv64, sr64;
    logic [63:0] a64, b64, res64;

    always #5 clk = ~clk;

    mult_seq_param #(.XLEN(32), .BITS_PER_CYCLE(8)) dut32 (
        .clk_i(clk), .rst_i(rst_n), .req_valid_i(rv32), .req_ready_o(rr32),
        .op_A_i(a32), .op_B_i(b32), .signed_A_i(sa32), .signed_B_i(sb32),
        .upper_i(up32), .kill_i(k32), .rsp_valid_o(sv32), .rsp_ready_i(sr32),
        .result_o(res32)
    );

    mult_seq_param #(.XLEN(64), .BITS_PER_CYCLE(16)) dut64 (
        .clk_i(clk), .rst_i(rst_n), .req_valid_i(rv64), .req_ready_o(rr64),
        .op_A_i(a64), .op_B_i(b64), .signed_A_i(sa64), .signed_B_i(sb64),
        .upper_i(up64), .kill_i(k64), .rsp_valid_o(sv64), .rsp_ready_i(sr64),
        .result_o(res64)
    );

    int          passed = 0, total = 0;
    logic [63:0] q32[$], q64[$];
    bit          cv[2];
    logic [63:0] ca[2], cb[2];
    bit          csa[2], csb[2];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic fail(input string msg);
        total++;
        $display("FAIL %s", msg);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Exact product of the operands as wide signed integers, then the requested half.
    function automatic logic [63:0] model(input bit w, input logic [63:0] a, input logic [63:0] b,
                                          input bit sa, input bit sb, input bit up);
        logic signed [129:0] ea, eb, p;
        if (w) begin
            ea = sa ? {{66{a[63]}}, a} : {66'b0, a};
            eb = sb ? {{66{b[63]}}, b} : {66'b0, b};
        end else begin
            ea = sa ? {{98{a[31]}}, a[31:0]} : {98'b0, a[31:0]};
            eb = sb ? {{98{b[31]}}, b[31:0]} : {98'b0, b[31:0]};
        end
        p = ea * eb;
        if (w) return up ? p[127:64] : p[63:0];
        return {32'b0, up ? p[63:32] : p[31:0]};
    endfunction

    function automatic logic [63:0] pick(input bit w);
        logic [63:0] r;
        case ($urandom_range(0, 5))
            0: r = '0;
            1: r = '1;
            2: r = w ? 64'h8000_0000_0000_0000 : 64'h8000_0000;
            3: r = 64'd1;
            default: r = {$urandom, $urandom};
        endcase
        return w ? r : {32'b0, r[31:0]};
    endfunction

    function automatic logic valid_o(input bit w);
        return w ? sv64 : sv32;
    endfunction

    function automatic logic ready_o(input bit w);
        return w ? rr64 : rr32;
    endfunction

    function automatic logic [63:0] res_o(input bit w);
        return w ? res64 : {32'b0, res32};
    endfunction

    task automatic set(input bit w, input bit v, input logic [63:0] a, input logic [63:0] b,
                       input bit sa, input bit sb, input bit up);
        if (w) begin
            rv64 = v; a64 = a; b64 = b; sa64 = sa; sb64 = sb; up64 = up;
        end else begin
            rv32 = v; a32 = a[31:0]; b32 = b[31:0]; sa32 = sa; sb32 = sb; up32 = up;
        end
    endtask

    task automatic drop(input bit w);
        if (w) rv64 = 1'b0;
        else rv32 = 1'b0;
    endtask

    task automatic set_rr(input bit w, input bit v);
        if (w) sr64 = v;
        else sr32 = v;
    endtask

    // Issue one request, check its latency against the bench's own cache model and,
    // optionally, hold the response for `hold` cycles checking it stays put.
    task automatic run(input bit w, input logic [63:0] a_in, input logic [63:0] b_in,
                       input bit sa, input bit sb, input bit up, input int hold);
        logic [63:0] a, b, r;
        bit hit;
        int lat;
        a = w ? a_in : {32'b0, a_in[31:0]};
        b = w ? b_in : {32'b0, b_in[31:0]};
        hit = cv[w] && ca[w] == a && cb[w] == b && csa[w] == sa && csb[w] == sb;
        chk("req_ready_idle", 64'(ready_o(w)), 64'(1));
        set_rr(w, hold == 0);
        set(w, 1'b1, a, b, sa, sb, up);
        if (w) q64.push_back(model(w, a, b, sa, sb, up));
        else q32.push_back(model(w, a, b, sa, sb, up));
        step();
        drop(w);
        lat = 1;
        while (!valid_o(w) && lat < 40) begin
            step();
            lat++;
        end
        chk(hit ? "hit_latency" : "miss_latency", 64'(lat), 64'(hit ? 1 : LAT_MISS));
        cv[w] = 1'b1; ca[w] = a; cb[w] = b; csa[w] = sa; csb[w] = sb;
        if (hold > 0) begin
            r = res_o(w);
            repeat (hold) begin
                step();
                chk("hold_valid", 64'(valid_o(w)), 64'(1));
                chk("hold_result", res_o(w), r);
                chk("hold_req_ready", 64'(ready_o(w)), 64'(0));
            end
            set_rr(w, 1'b1);
        end
        step();
    endtask

    always @(negedge clk) begin
        if (rst_n && sv32 && sr32) begin
            if (q32.size() == 0) fail("rsp32 with no request outstanding");
            else chk("rsp32_result", {32'b0, res32}, q32.pop_front());
        end
        if (rst_n && sv64 && sr64) begin
            if (q64.size() == 0) fail("rsp64 with no request outstanding");
            else chk("rsp64_result", res64, q64.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] a, b;
        bit sa, sb, up, seen;
        rst_n = 1'b0;
        set(0, 0, '0, '0, 0, 0, 0);
        set(1, 0, '0, '0, 0, 0, 0);
        k32 = 1'b0; k64 = 1'b0; sr32 = 1'b1; sr64 = 1'b1;
        #12;
        chk("rst_req_ready32", 64'(rr32), 64'(1));
        chk("rst_rsp_valid32", 64'(sv32), 64'(0));
        chk("rst_result32", 64'(res32), 64'(0));
        chk("rst_req_ready64", 64'(rr64), 64'(1));
        chk("rst_rsp_valid64", 64'(sv64), 64'(0));
        chk("rst_result64", res64, 64'(0));
        @(posedge clk);
        #2 rst_n = 1'b1;
        step();

        run(0, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 0, 0, 1, 0);
        run(0, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 0, 0, 0, 0);
        run(0, 64'h8000_0000, 64'h8000_0000, 1, 1, 1, 0);
        run(0, 64'h8000_0000, 64'h8000_0000, 1, 1, 0, 0);
        run(0, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 1, 0, 1, 0);
        run(0, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 1, 0, 0, 0);

        // kill while idle blocks acceptance but leaves the cache intact
        set(0, 1'b1, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 1, 0, 1);
        k32 = 1'b1;
        step();
        drop(0);
        k32 = 1'b0;
        chk("idle_kill_ready", 64'(rr32), 64'(1));
        chk("idle_kill_valid", 64'(sv32), 64'(0));
        step();
        chk("idle_kill_no_rsp", 64'(sv32), 64'(0));
        run(0, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 1, 0, 1, 0);

        // kill in the third BUSY cycle
        set(0, 1'b1, 64'h1234_5678, 64'h9ABC_DEF0, 0, 0, 1);
        step();
        drop(0);
        step();
        step();
        k32 = 1'b1;
        step();
        k32 = 1'b0;
        chk("kill_rsp_valid", 64'(sv32), 64'(0));
        chk("kill_req_ready", 64'(rr32), 64'(1));
        cv[0] = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            step();
            seen |= sv32;
        end
        chk("kill_no_rsp", 64'(seen), 64'(0));
        run(0, 64'h1234_5678, 64'h9ABC_DEF0, 0, 0, 1, 0);

        run(0, 64'hDEAD_BEEF, 64'h0BAD_F00D, 1, 1, 1, 5);

        a = '0; b = '0; sa = 0; sb = 0; up = 0;
        for (int i = 0; i < 10; i++) begin
            if (i > 0 && $urandom_range(0, 3) == 0) up = !up;
            else begin
                a = pick(0); b = pick(0);
                sa = 1'($urandom_range(0, 1)); sb = 1'($urandom_range(0, 1)); up = 1'($urandom_range(0, 1));
            end
            run(0, a, b, sa, sb, up, 0);
        end
        for (int i = 0; i < 16; i++) begin
            if (i > 0 && $urandom_range(0, 3) == 0) up = !up;
            else begin
                a = pick(1); b = pick(1);
                sa = 1'($urandom_range(0, 1)); sb = 1'($urandom_range(0, 1)); up = 1'($urandom_range(0, 1));
            end
            run(1, a, b, sa, sb, up, 0);
        end

        // asynchronous reset in the middle of a 64-bit BUSY phase
        run(0, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 0, 0, 1, 0);
        run(1, '1, '1, 0, 0, 1, 0);
        set(1, 1'b1, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1, 0, 1);
        step();
        drop(1);
        step();
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_valid64", 64'(sv64), 64'(0));
        chk("async_rst_ready64", 64'(rr64), 64'(1));
        chk("async_rst_result64", res64, 64'(0));
        chk("async_rst_result32", 64'(res32), 64'(0));
        step();
        rst_n = 1'b1;
        cv[0] = 1'b0;
        cv[1] = 1'b0;
        step();
        run(1, '1, '1, 0, 0, 1, 0);

        repeat (3) step();
        chk("q32_drained", 64'(q32.size()), 64'(0));
        chk("q64_drained", 64'(q64.size()), 64'(0));
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mult_seq_param.md
# mult_seq_param

Parametrised sequential integer multiplier for the RV32M/RV64M execute stage, generalising the fixed 32-bit, fixed-latency multiplier. It computes MUL/MULH/MULHSU/MULHU, retiring BITS_PER_CYCLE multiplier bits per cycle. It uses valid/ready handshakes on both request and response, and supports a kill input. A one-entry product cache answers a repeated operand pair (e.g. MULH followed by MUL) in one cycle.

## Interface
- XLEN, 32: operand and result width; 32 or 64.
- BITS_PER_CYCLE, 8: multiplier bits retired per iteration; power of two, divides XLEN.
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset; asynchronous, active-low.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  block can accept a request.
- op_A_i  in  XLEN  multiplicand.
- op_B_i  in  XLEN  multiplier.
- signed_A_i  in  1  op_A is two's complement.
- signed_B_i  in  1  op_B is two's complement.
- upper_i  in  1  return product bits [2*XLEN-1:XLEN], else [XLEN-1:0].
- kill_i  in  1  abort the in-flight operation.
- rsp_valid_o  out  1  result valid.
- rsp_ready_i  in  1  consumer takes result.
- result_o  out  XLEN  selected product half.

## Operation
- States: IDLE, BUSY, SIGN, DONE.
- Reset: state IDLE, req_ready_o=1, rsp_valid_o=0, result_o=0, cache invalid.
- IDLE, accept (req_valid_i & req_ready_o):
  - latch upper_i, the operands and the sign flags.
  - neg = (signed_A & A[XLEN-1]) ^ (signed_B & B[XLEN-1]).
  - Latch magnitudes |A| and |B|; the most negative value maps to 2^(XLEN-1), unsigned.
  - Clear the accumulator and the counter.
  - Cache hit (cache valid, and A, B, signed_A, signed_B all equal the cached tag): go to DONE; result comes from the cached product. Otherwise go to BUSY.
- BUSY, each cycle:
  - acc = acc + |A| * B_mag[digit] << (digit*BITS_PER_CYCLE), digit = counter.
  - The accumulator is 2*XLEN bits wide; no carry is lost.
  - Counter increments. After N_ITER = XLEN/BITS_PER_CYCLE iterations, go to SIGN.
- SIGN, one cycle:
  - product = neg ? -acc : acc, modulo 2^(2*XLEN).
  - Write the product and tag to the cache, set it valid, go to DONE.
- DONE: rsp_valid_o=1; result_o is the stable selected half. On rsp_ready_i go to IDLE.
- req_ready_o=1 only in IDLE; no request is accepted in the same cycle as a response handshake.
- kill_i in any state:
  - Next state is IDLE, rsp_valid_o drops, and no response is produced.
  - The cache is invalidated unless the state is IDLE.
  - kill_i in IDLE blocks acceptance that cycle.
- Any reset assertion mid-operation returns to reset values asynchronously.

## Timing
- Accept at edge 0; miss sets rsp_valid_o after edge N_ITER+2 (XLEN=32, BPC=8: 6 cycles; BPC=4: 10 cycles).
- Hit sets rsp_valid_o after edge 1.
- Throughput with continuous rsp_ready_i: one result per N_ITER+3 cycles on a miss, per 2 cycles on a hit.
- result_o is a register, driven from the product register and the latched upper flag; it holds until the response handshake. There is no combinational path from the inputs to the outputs.
- Critical path: one BITS_PER_CYCLE x XLEN partial-product add into the 2*XLEN accumulator.

## Structure
- Package mult_pkg:
  - state enum: IDLE, BUSY, SIGN, DONE.
  - function for N_ITER, and a counter width of clog2(N_ITER), minimum 1.
  - Elaboration check that BITS_PER_CYCLE is a power of two and divides XLEN.
- Sub-module mult_step (combinational): |A| times a BITS_PER_CYCLE digit, shifted and added to the accumulator.
- The top holds the FSM, the counter, the operand, accumulator and product registers, and the cache tag and data.

## Test plan
- MULHU 0xFFFFFFFF x 0xFFFFFFFF, BPC=8: response after 6 cycles with result 0xFFFFFFFE. Repeat with upper=0: hit, response after 1 cycle with 0x00000001.
- MULH signed 0x80000000 x 0x80000000: result 0x40000000. Then MUL signed on the same pair: hit with 0x00000000.
- MULHSU A=0xFFFFFFFF (signed) x B=0xFFFFFFFF (unsigned): upper 0xFFFFFFFF; lower via hit 0x00000001.
- kill_i in the third BUSY cycle:
  - no rsp_valid_o; req_ready_o is 1 in the next cycle.
  - the same operands re-issued miss and take the full 6 cycles.
- rsp_ready_i held low 5 cycles: result_o and rsp_valid_o stay stable; req_ready_o stays 0.
- XLEN=64, BPC=16, random signed/unsigned pairs checked against a reference model:
  - 6-cycle latency.
  - reset asserted mid-BUSY clears outputs asynchronously.
